// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Write-back stage in front of the register file. It collects results from the
//   load unit, the ALU and the multiply/divide unit, and keeps them in a small
//   FIFO. It issues at most one register write per cycle, in acceptance order.
//   A multiply/divide result is stored as two entries: lo to md_addr, then hi to
//   MD_HI_ADDR. Both entries are pushed at the same edge, so no other result can
//   land between them.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   ld_*   (valid/addr/data/ready)   load result producer   (highest priority)
//   alu_*  (valid/addr/data/ready)   ALU result producer
//   md_*   (valid/addr/data/ready)   multiply/divide result {hi, lo} (lowest)
//   wr, wrAddr, wrData   register-file write port, driven from the FIFO head
//   pend_mask            bit r set while any queued entry targets register r
//   count                occupied FIFO entries
//
// Handshake: a producer raises valid and holds valid, addr and data stable
// until it sees ready high. The transfer happens at the rising edge where both
// valid and ready are high. Each ready is combinational from the valids and
// count, and is forced low while rst is low.
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int MD_HI_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [ADDR_W-1:0]         alu_addr,
    input  logic [DATA_W-1:0]         alu_data,
    output logic                      alu_ready,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    input  logic                      md_valid,
    input  logic [ADDR_W-1:0]         md_addr,
    input  logic [2*DATA_W-1:0]       md_data,
    output logic                      md_ready,
    output logic                      wr,
    output logic [ADDR_W-1:0]         wrAddr,
    output logic [DATA_W-1:0]         wrData,
    output logic [2**ADDR_W-1:0]      pend_mask,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] HI_ADDR = ADDR_W'(MD_HI_ADDR);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     wr_ptr_p1;
    logic [CW-1:0]     cnt;

    logic              pop;
    logic [CW-1:0]     free;
    logic              push_one;
    logic              push_two;
    logic [1:0]        push_n;
    logic [ADDR_W-1:0] one_addr;
    logic [DATA_W-1:0] one_data;
    logic [PW-1:0]     slot_off [DEPTH];

    // The register file always accepts, so the head leaves every cycle the
    // FIFO is non-empty.
    assign pop = (cnt != '0);

    // The slot freed by this cycle's pop is already usable for this cycle's push.
    assign free = CW'(DEPTH) - cnt + CW'(pop);

    assign ld_ready  = rst & ld_valid & (free >= CW'(1));
    assign alu_ready = rst & alu_valid & ~ld_valid & (free >= CW'(1));
    assign md_ready  = rst & md_valid & ~ld_valid & ~alu_valid & (free >= CW'(2));

    assign push_one = ld_ready | alu_ready;
    assign push_two = md_ready;
    assign push_n   = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
    assign one_addr = ld_ready ? ld_addr : alu_addr;
    assign one_data = ld_ready ? ld_data : alu_data;

    assign wr_ptr_p1 = wr_ptr + PW'(1);

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_two) begin
                wr_ptr <= wr_ptr + PW'(2);
            end else if (push_one) begin
                wr_ptr <= wr_ptr_p1;
            end
            cnt <= cnt - CW'(pop) + CW'(push_n);
        end
    end

    // Storage. The ready signals are already gated by rst, so the storage
    // needs no reset. A two-entry push may straddle the pointer wrap.
    always_ff @(posedge clk) begin
        if (push_one) begin
            mem_addr[wr_ptr] <= one_addr;
            mem_data[wr_ptr] <= one_data;
        end else if (push_two) begin
            mem_addr[wr_ptr]    <= md_addr;
            mem_data[wr_ptr]    <= md_data[DATA_W-1:0];
            mem_addr[wr_ptr_p1] <= HI_ADDR;
            mem_data[wr_ptr_p1] <= md_data[2*DATA_W-1:DATA_W];
        end
    end

    assign wr     = pop;
    assign wrAddr = pop ? mem_addr[rd_ptr] : '0;
    assign wrData = pop ? mem_data[rd_ptr] : '0;
    assign count  = cnt;

    // A slot holds a queued entry when its distance from the head is below the
    // occupancy.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = PW'(i) - rd_ptr;
            if ({1'b0, slot_off[i]} < cnt) begin
                pend_mask[mem_addr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//   Self-checking bench for regfile_wb_queue. The reference is a queue of
//   pending {addr, data} writes. Each cycle the bench derives readys, the write
//   port, the pending mask and the count from that queue and from the
//   arbitration rules.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int W     = AW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0, ld_valid = 1'b0, md_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0, ld_addr = '0, md_addr = '0;
    logic [DW-1:0] alu_data = '0, ld_data = '0;
    logic [2*DW-1:0] md_data = '0;
    logic          alu_ready, ld_ready, md_ready;
    logic          wr;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;
    logic [15:0]   pend_mask;
    logic [2:0]    count;

    // clock / reset
    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .MD_HI_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .wr(wr), .wrAddr(wrAddr), .wrData(wrData), .pend_mask(pend_mask), .count(count)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic acc_ld, acc_alu, acc_md;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected behaviour for the current cycle, computed from the pending queue.
    task automatic model_check();
        int n;
        int free;
        logic [15:0] p;
        n    = exp_q.size();
        free = DEPTH - n + ((n != 0) ? 1 : 0);
        acc_ld  = rst && ld_valid && free >= 1;
        acc_alu = rst && alu_valid && !ld_valid && free >= 1;
        acc_md  = rst && md_valid && !ld_valid && !alu_valid && free >= 2;
        p = '0;
        foreach (exp_q[i]) p[exp_q[i][W-1:DW]] = 1'b1;
        check("ld_ready",  32'(ld_ready),  32'(acc_ld));
        check("alu_ready", 32'(alu_ready), 32'(acc_alu));
        check("md_ready",  32'(md_ready),  32'(acc_md));
        check("wr",        32'(wr),        32'(n != 0));
        check("wrAddr",    32'(wrAddr),    (n != 0) ? 32'(exp_q[0][W-1:DW]) : 32'd0);
        check("wrData",    32'(wrData),    (n != 0) ? 32'(exp_q[0][DW-1:0]) : 32'd0);
        check("pend_mask", 32'(pend_mask), 32'(p));
        check("count",     32'(count),     32'(n));
    endtask

    // One clock: check at negedge, update the model at posedge, then retire
    // accepted requests. In random mode, idle producers may offer new ones.
    task automatic cycle(input bit rnd);
        @(negedge clk);
        model_check();
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc_ld)       exp_q.push_back({ld_addr, ld_data});
            else if (acc_alu) exp_q.push_back({alu_addr, alu_data});
            else if (acc_md) begin
                exp_q.push_back({md_addr, md_data[DW-1:0]});
                exp_q.push_back({4'd0, md_data[2*DW-1:DW]});
            end
        end
        #1;
        if (acc_ld)  ld_valid  = 1'b0;
        if (acc_alu) alu_valid = 1'b0;
        if (acc_md)  md_valid  = 1'b0;
        if (rnd) begin
            if (!ld_valid && $urandom_range(0, 3) == 0) begin
                ld_valid = 1'b1; ld_addr = AW'($urandom_range(0, 15)); ld_data = DW'($urandom);
            end
            if (!alu_valid && $urandom_range(0, 2) == 0) begin
                alu_valid = 1'b1; alu_addr = AW'($urandom_range(0, 15)); alu_data = DW'($urandom);
            end
            if (!md_valid && $urandom_range(0, 2) == 0) begin
                md_valid = 1'b1; md_addr = AW'($urandom_range(0, 15)); md_data = $urandom;
            end
        end
    endtask

    task automatic idle_drain(input int n);
        ld_valid = 1'b0; alu_valid = 1'b0; md_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        // Reset with every producer offering
        rst = 1'b0;
        ld_valid = 1'b1;  ld_addr = 4'd1;  ld_data = 16'h1111;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h2222;
        md_valid = 1'b1;  md_addr = 4'd9;  md_data = 32'hABCD_1234;
        @(posedge clk); #1;
        cycle(1'b0);
        cycle(1'b0);
        rst = 1'b1;
        cycle(1'b0);
        check("post_reset_first_ld", 32'(wrAddr), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0);
        idle_drain(2);

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'hF033;
        cycle(1'b0);
        check("alu_single_addr", 32'(wrAddr), 32'd3);
        check("alu_single_data", 32'(wrData), 32'hF033);
        check("alu_single_pend", 32'(pend_mask), 32'h0008);
        cycle(1'b0);
        check("alu_single_cnt0", 32'(count), 32'd0);
        idle_drain(1);

        // Priority: all three offered together
        ld_valid = 1'b1;  ld_addr = 4'd5;  ld_data = 16'h0040;
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 16'h6666;
        md_valid = 1'b1;  md_addr = 4'd10; md_data = 32'h1357_2468;
        cycle(1'b0);
        check("prio_first", 32'(wrAddr), 32'd5);
        cycle(1'b0);
        check("prio_second", 32'(wrAddr), 32'd6);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        idle_drain(4);

        // Multiply split
        md_valid = 1'b1; md_addr = 4'd7; md_data = 32'h8888_00FF;
        cycle(1'b0);
        check("md_lo_addr", 32'(wrAddr), 32'd7);
        check("md_lo_data", 32'(wrData), 32'h00FF);
        cycle(1'b0);
        check("md_hi_addr", 32'(wrAddr), 32'd0);
        check("md_hi_data", 32'(wrData), 32'h8888);
        idle_drain(2);

        // Full and back-pressure: md fills the queue, then ALU keeps it full
        for (int i = 0; i < 14; i++) begin
            if (!md_valid) begin
                md_valid = 1'b1; md_addr = AW'($urandom_range(0, 15)); md_data = $urandom;
            end
            if (i >= 4 && i < 10 && !alu_valid) begin
                alu_valid = 1'b1; alu_addr = AW'($urandom_range(0, 15)); alu_data = DW'($urandom);
            end
            cycle(1'b0);
            check("count_max", 32'(count <= 3'd4), 32'd1);
        end
        idle_drain(6);

        // Random mixed traffic across many pointer wraps
        for (int i = 0; i < 400; i++) cycle(1'b1);
        idle_drain(6);

        // Reset mid-flight with three entries queued
        md_valid = 1'b1; md_addr = 4'd4; md_data = 32'hCAFE_BEEF;
        cycle(1'b0);
        md_valid = 1'b1; md_addr = 4'd8; md_data = 32'h0BAD_F00D;
        cycle(1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        rst = 1'b0;
        ld_valid = 1'b1; alu_valid = 1'b1; md_valid = 1'b1;
        cycle(1'b0);
        check("reset_wr", 32'(wr), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        rst = 1'b1;
        idle_drain(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back stage directly upstream of the 16 x 16-bit register file; sole driver of its wr/wrAddr/wrData port.
- Accepts results from three producers and serializes them into at most one register write per cycle:
  - ALU: 16-bit result.
  - Load/store unit: 16-bit load data.
  - Multiply/divide unit: 32-bit result, written as two registers.
- Buffers results in a small FIFO and exports a pending-write mask so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, register address width.
- DATA_W, 16, register data width.
- MD_HI_ADDR, 0, destination register for the upper half of a multiply/divide result.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is high
- ld_valid  in  1  load result offered
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load result accepted this cycle when ld_valid is high
- md_valid  in  1  multiply/divide result offered
- md_addr  in  ADDR_W  destination register for the lower half
- md_data  in  2*DATA_W  {hi, lo} result
- md_ready  out  1  multiply/divide result accepted this cycle when md_valid is high
- wr  out  1  register-file write enable
- wrAddr  out  ADDR_W  register-file write address
- wrData  out  DATA_W  register-file write data
- pend_mask  out  2**ADDR_W  bit r set while any queued entry targets register r
- count  out  log2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-low.
  - While rst=0 at a rising edge: FIFO empties, count=0.
  - With the FIFO empty, wr=0, wrAddr=0, wrData=0 and pend_mask=0.
  - All *_ready outputs are forced to 0 while rst=0.
  - Reset mid-operation discards all queued entries; no partial multiply/divide pair survives.
- FIFO: circular buffer of {addr, data} entries with read/write pointers and an occupancy counter.
- Drain:
  - Whenever count>0, wr=1 and wrAddr/wrData are driven combinationally from the FIFO head.
  - The head pops unconditionally at the next rising edge, because the register file always accepts.
  - When count=0: wr=0, wrAddr=0, wrData=0.
- Free-slot calculation includes the same-cycle pop: free = DEPTH - count + (count!=0 ? 1 : 0).
- Arbitration is fixed priority, ld > alu > md, with at most one producer accepted per cycle:
  - ld_ready = ld_valid and free>=1.
  - alu_ready = alu_valid and not ld_valid and free>=1.
  - md_ready = md_valid and not ld_valid and not alu_valid and free>=2.
  - A producer holds valid, addr and data stable until ready. The ready outputs are combinational from the valids and count.
- Enqueue (accept at edge N):
  - ALU or load: one entry.
  - Multiply/divide: two entries in order, {md_addr, md_data[15:0]} then {MD_HI_ADDR, md_data[31:16]}. The register file sees them on consecutive cycles, lo first.
  - The lo/hi pair is never split by another producer, since both entries are pushed at the same edge.
- Latency:
  - A result accepted at edge N into an empty FIFO drives wr=1 in the cycle after edge N and is written into the register file at edge N+1.
  - Otherwise the result writes after all older entries, in strict acceptance order.
- Counter update:
  - count_next = count - pop + push, with push in {0,1,2}.
  - Simultaneous push and pop when count==DEPTH is legal; an ALU/load push lands in the slot freed by the pop.
  - count never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH; the two-entry push may straddle the wrap.
- pend_mask is the OR over valid entries of a one-hot decode of the entry address. Two queued writes to the same register leave the bit set until both have drained.
- If md_addr equals MD_HI_ADDR, both writes are issued; the hi value lands last and is final.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with all valids high -> all readys 0, wr=0, count=0, pend_mask=0; release rst -> ld accepted first.
- Single ALU write: alu_valid=1, addr=3, data=16'hF033 at edge N -> wr=1, wrAddr=3, wrData=16'hF033 in the following cycle; pend_mask=16'h0008 for that cycle only; count returns to 0 after edge N+1.
- Priority: ld (addr 5, 16'h0040), alu (addr 6, 16'h6666) and md all valid together -> write order R5, R6, then md pair; ld_ready before alu_ready before md_ready.
- Multiply split: md_valid=1, md_addr=7, md_data=32'h8888_00FF -> two consecutive writes, R7=16'h00FF then R0=16'h8888, back to back with no other write between.
- Full/back-pressure: stall the drain by holding FIFO at DEPTH=4 with one ALU entry per cycle plus an md request -> md_ready=0 while free<2; ALU still accepted when count=4, since pop frees a slot; count never exceeds 4.
- Wrap and reset mid-flight: issue 10 mixed writes spanning pointer wrap and check order and data; then assert rst=0 with count=3 -> next cycle wr=0, count=0, and no stale write appears after release.
